// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/halt sequencer.
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_go_sync_edge.sv
// Two-flop synchroniser for the asynchronous go button plus rising-edge pulse.
module go_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic go_i,
    output logic pulse_o
);
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= go_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Pulse is visible in the cycle after the second sync edge, so the FSM
    // acts on it at the third edge after go rises.
    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding sequencer and halt/resume FSM for the 5-stage core.
// Statistics counters exist only when PIPE_HAZARD_STAT_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_r1,
    input  logic [REG_AW-1:0] id_r2,
    input  logic              id_r1_used,
    input  logic              id_r2_used,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] ex_r1,
    input  logic [REG_AW-1:0] ex_r2,
    input  logic              ex_r1_used,
    input  logic              ex_r2_used,
    input  logic              ex_memtoreg,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              ex_branch_taken,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic              wb_syscall_halt,
    input  logic              go,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_clr,
    output logic              idex_clr,
    output logic              exmem_clr,
    output logic              memwb_clr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_e state_q, state_d;
    logic   halted_q;
    logic   go_pulse;
    logic   load_use;

    go_sync_edge u_go_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .go_i    (go),
        .pulse_o (go_pulse)
    );

    assign load_use = ex_memtoreg && ex_regwrite && (ex_wreg != '0) &&
                      ((id_r1_used && (id_r1 == ex_wreg)) ||
                       (id_r2_used && (id_r2 == ex_wreg)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALT);
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        memwb_clr = 1'b0;
        case (state_q)
            ST_HALT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                if (go_pulse) state_d = ST_DRAIN;
            end
            default: begin
                // A taken branch squashes the stalled instruction, so it beats load-use.
                if (ex_branch_taken) begin
                    ifid_clr = 1'b1;
                    idex_clr = 1'b1;
                end else if (load_use) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_clr = 1'b1;
                end else if (id_jump) begin
                    ifid_clr = 1'b1;
                end
                if (state_q == ST_DRAIN) begin
                    memwb_clr = 1'b1;
                    state_d   = ST_RUN;
                end else if (wb_syscall_halt) begin
                    state_d   = ST_HALT;
                end
            end
        endcase
        if (!rst_n) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
            memwb_clr = 1'b1;
        end
    end

    assign halted = halted_q;

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    assign fwd_a = (ex_r1_used && mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_r1)) ? FWD_MEM :
                   (ex_r1_used && wb_regwrite  && (wb_wreg  != '0) && (wb_wreg  == ex_r1)) ? FWD_WB  :
                   FWD_RF;
    assign fwd_b = (ex_r2_used && mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_r2)) ? FWD_MEM :
                   (ex_r2_used && wb_regwrite  && (wb_wreg  != '0) && (wb_wreg  == ex_r2)) ? FWD_WB  :
                   FWD_RF;

`ifdef PIPE_HAZARD_STAT_EN
    logic             active;
    logic [CNT_W-1:0] cycle_q, stall_q, flush_q;

    assign active = (state_q != ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (active)                                cycle_q <= cycle_q + 1'b1;
            if (active && load_use && !ex_branch_taken) stall_q <= stall_q + 1'b1;
            if (active && ex_branch_taken)             flush_q <= flush_q + 1'b1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (stats expectations follow PIPE_HAZARD_STAT_EN).
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk, rst_n;
    logic [4:0]  id_r1, id_r2, ex_r1, ex_r2, ex_wreg, mem_wreg, wb_wreg;
    logic        id_r1_used, id_r2_used, id_jump, ex_r1_used, ex_r2_used;
    logic        ex_memtoreg, ex_regwrite, ex_branch_taken, mem_regwrite, wb_regwrite;
    logic        wb_syscall_halt, go;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_clr, idex_clr, exmem_clr, memwb_clr;
    logic [1:0]  fwd_a, fwd_b;
    logic        halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [4:0]  en_v;
    logic [3:0]  clr_v;

    int n_chk = 0;
    int n_err = 0;
    int exp_cyc = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    bit in_halt = 1'b0;

    assign en_v  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign clr_v = {ifid_clr, idex_clr, exmem_clr, memwb_clr};

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_r1(id_r1), .id_r2(id_r2), .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .id_jump(id_jump), .ex_r1(ex_r1), .ex_r2(ex_r2),
        .ex_r1_used(ex_r1_used), .ex_r2_used(ex_r2_used),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg),
        .ex_branch_taken(ex_branch_taken), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
        .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .wb_syscall_halt(wb_syscall_halt),
        .go(go), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
        .exmem_clr(exmem_clr), .memwb_clr(memwb_clr), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!in_halt) exp_cyc++;
    endtask

    task automatic clear_in();
        {id_r1, id_r2, ex_r1, ex_r2, ex_wreg, mem_wreg, wb_wreg} = '0;
        {id_r1_used, id_r2_used, id_jump, ex_r1_used, ex_r2_used} = '0;
        {ex_memtoreg, ex_regwrite, ex_branch_taken, mem_regwrite, wb_regwrite} = '0;
        wb_syscall_halt = 1'b0;
    endtask

    task automatic set_load_use();
        ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8;
        id_r1 = 5'd8; id_r1_used = 1'b1;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_cycle"}, cycle_cnt, STAT ? 32'(exp_cyc)   : 32'd0);
        chk({tag, "_stall"}, stall_cnt, STAT ? 32'(exp_stall) : 32'd0);
        chk({tag, "_flush"}, flush_cnt, STAT ? 32'(exp_flush) : 32'd0);
    endtask

    initial begin
        clear_in();
        go = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("rst_en", 32'(en_v), 32'h00);
        chk("rst_clr", 32'(clr_v), 32'hf);
        chk("rst_halted", 32'(halted), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("run_en", 32'(en_v), 32'h1f);
        chk("run_clr", 32'(clr_v), 32'h0);

        // Load-use stall for one cycle
        set_load_use(); #1;
        chk("lu_en", 32'(en_v), 32'b00111);
        chk("lu_clr", 32'(clr_v), 32'b0100);
        tick(); exp_stall++;
        ex_memtoreg = 1'b0; #1;
        chk("lu_after_en", 32'(en_v), 32'h1f);
        chk("lu_after_clr", 32'(clr_v), 32'h0);
        chk_stats("lu");

        // Register 0 never causes a stall
        ex_memtoreg = 1'b1; ex_wreg = 5'd0; id_r1 = 5'd0; #1;
        chk("lu_r0_en", 32'(en_v), 32'h1f);

        // Branch overrides load-use
        clear_in(); set_load_use(); ex_branch_taken = 1'b1; #1;
        chk("br_en", 32'(en_v), 32'h1f);
        chk("br_clr", 32'(clr_v), 32'b1100);
        tick(); exp_flush++;
        clear_in(); #1;
        chk_stats("br");

        // Jump in ID, alone and suppressed by load-use
        id_jump = 1'b1; #1;
        chk("jmp_clr", 32'(clr_v), 32'b1000);
        chk("jmp_en", 32'(en_v), 32'h1f);
        set_load_use(); #1;
        chk("jmp_lu_clr", 32'(clr_v), 32'b0100);
        chk("jmp_lu_en", 32'(en_v), 32'b00111);
        clear_in(); #1;

        // Forwarding priority and r0 exclusion
        ex_r1 = 5'd5; ex_r1_used = 1'b1; mem_wreg = 5'd5; wb_wreg = 5'd5;
        mem_regwrite = 1'b1; wb_regwrite = 1'b1; #1;
        chk("fwd_a_mem", 32'(fwd_a), 32'b01);
        mem_regwrite = 1'b0; #1;
        chk("fwd_a_wb", 32'(fwd_a), 32'b10);
        ex_r1 = 5'd0; mem_wreg = 5'd0; wb_wreg = 5'd0; mem_regwrite = 1'b1; #1;
        chk("fwd_a_r0", 32'(fwd_a), 32'b00);
        ex_r2 = 5'd9; ex_r2_used = 1'b1; mem_wreg = 5'd9; #1;
        chk("fwd_b_mem", 32'(fwd_b), 32'b01);
        ex_r2_used = 1'b0; #1;
        chk("fwd_b_unused", 32'(fwd_b), 32'b00);
        clear_in(); #1;

        // Halt entry
        wb_syscall_halt = 1'b1; #1;
        chk("halt_req_en", 32'(en_v), 32'h1f);
        tick(); in_halt = 1'b1;
        chk("halted", 32'(halted), 32'd1);
        chk("halt_en", 32'(en_v), 32'h00);
        chk("halt_clr", 32'(clr_v), 32'h0);
        set_load_use(); ex_r1 = 5'd3; ex_r1_used = 1'b1; mem_wreg = 5'd3; mem_regwrite = 1'b1; #1;
        chk("halt_lu_clr", 32'(clr_v), 32'h0);
        chk("halt_fwd_a", 32'(fwd_a), 32'b01);
        clear_in(); wb_syscall_halt = 1'b1; #1;

        // Resume: go_pulse acts on the third edge after go rises
        go = 1'b1;
        tick();
        chk("go1_en", 32'(en_v), 32'h00);
        tick();
        chk("go2_halted", 32'(halted), 32'd1);
        tick(); in_halt = 1'b0;
        chk("drain_clr", 32'(clr_v), 32'b0001);
        chk("drain_en", 32'(en_v), 32'h1f);
        chk("drain_halted", 32'(halted), 32'd0);
        tick();
        wb_syscall_halt = 1'b0; go = 1'b0; #1;
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_clr", 32'(clr_v), 32'h0);
        chk_stats("resume");

        // Halt together with a branch: hazard response still applied
        wb_syscall_halt = 1'b1; ex_branch_taken = 1'b1; #1;
        chk("halt_br_clr", 32'(clr_v), 32'b1100);
        tick(); in_halt = 1'b1; exp_flush++;
        clear_in(); #1;
        chk("halt_br_halted", 32'(halted), 32'd1);

        // Async reset mid-HALT
        #2 rst_n = 1'b0;
        #1;
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_en", 32'(en_v), 32'h00);
        chk("arst_clr", 32'(clr_v), 32'hf);
        @(posedge clk); #1;
        rst_n = 1'b1; in_halt = 1'b0;
        exp_cyc = 0; exp_stall = 0; exp_flush = 0;
        #1;
        chk("arst_run_en", 32'(en_v), 32'h1f);
        chk_stats("arst");
        tick();
        chk("arst_tick_halted", 32'(halted), 32'd0);
        chk_stats("arst_tick");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC of the 5-stage MIPS core.
- Drives the enable and synchronous-clear inputs of each pipeline register and the PC enable.
- Generates EX-stage forwarding selects.
- Runs a halt/resume state machine for the halting syscall.

Parameters:
- REG_AW, 5, register-number width
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_r1, id_r2  in  REG_AW each  source register numbers of instruction in ID
- id_r1_used, id_r2_used  in  1 each  ID instruction reads r1/r2
- id_jump  in  1  Jmp or Jal decoded in ID
- ex_r1, ex_r2  in  REG_AW each  source register numbers held in ID/EX
- ex_r1_used, ex_r2_used  in  1 each  from ID/EX
- ex_memtoreg, ex_regwrite  in  1 each  from ID/EX
- ex_wreg  in  REG_AW  from ID/EX
- ex_branch_taken  in  1  resolved beq/bne/blez/bgtz/bz/jr taken in EX
- mem_regwrite  in  1  from EX/MEM
- mem_wreg  in  REG_AW  from EX/MEM
- wb_regwrite  in  1  from MEM/WB
- wb_wreg  in  REG_AW  from MEM/WB
- wb_syscall_halt  in  1  halting syscall in WB
- go  in  1  asynchronous resume button, level
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each
- ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each
- fwd_a, fwd_b  out  2 each  00 register file, 01 EX/MEM result, 10 MEM/WB result
- halted  out  1  registered; high in HALT
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  statistics

Behaviour:
- Reset (rst_n low, async):
  - state=RUN, halted=0, go synchroniser flops=0, counters=0.
  - While rst_n is low, all *_en=0 and all *_clr=1.
- States:
  - RUN: normal operation.
  - HALT: pipeline frozen.
  - DRAIN: single cycle that lets the syscall leave WB.
- go input: passes through a 2-flop synchroniser, then rising-edge detect. go_pulse lasts 1 cycle and arrives 3 cycles after the asynchronous edge.
- Transitions:
  - RUN→HALT when wb_syscall_halt=1.
  - HALT→DRAIN on go_pulse.
  - DRAIN→RUN unconditionally.
  - wb_syscall_halt is ignored in DRAIN and HALT.
- HALT outputs: all *_en=0, all *_clr=0, halted=1 from the cycle after entry.
- DRAIN outputs: all *_en=1, memwb_clr=1, hazard logic active.
- RUN default: all *_en=1, all *_clr=0.
- Hazard logic in RUN/DRAIN is combinational, same cycle.
- Load-use: ex_memtoreg & ex_regwrite & ex_wreg!=0 & ((id_r1_used & id_r1==ex_wreg) | (id_r2_used & id_r2==ex_wreg)).
  - Response: pc_en=0, ifid_en=0, idex_clr=1 (bubble). Lasts exactly 1 cycle.
- Branch flush: ex_branch_taken → ifid_clr=1, idex_clr=1, pc_en=1. Overrides load-use stall, since the stalled instruction is on the wrong path.
- Jump in ID: id_jump & !ex_branch_taken & !load-use → ifid_clr=1.
- Register enables are unaffected by clr. Each pipeline register treats clr as higher priority than en.
- Forwarding (fwd_a uses ex_r1/ex_r1_used; fwd_b uses ex_r2/ex_r2_used):
  - 01 if mem_regwrite & mem_wreg!=0 & match.
  - Else 10 if wb_regwrite & wb_wreg!=0 & match.
  - Else 00.
  - EX/MEM has priority over MEM/WB.
  - Register 0 never forwards.
  - The select is valid in all states.
- Simultaneous wb_syscall_halt with a branch or load-use in RUN: the halt wins. The next state is HALT, and this cycle's outputs still apply the hazard response.
- If reset asserts mid-HALT, the state returns to RUN.

Optional Feature:
- Macro: PIPE_HAZARD_STAT_EN.
- With the macro defined:
  - cycle_cnt increments every cycle the state is not HALT.
  - stall_cnt increments on each load-use stall cycle.
  - flush_cnt increments on each ex_branch_taken cycle in RUN/DRAIN.
  - All counters wrap modulo 2^CNT_W.
- Without the macro: all three outputs are constant 0 and no counter flops are inferred.

Decomposition:
- Shared package holds:
  - FSM state encoding: RUN=2'd0, HALT=2'd1, DRAIN=2'd2.
  - Forwarding select constants: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - REG_AW default.
- One sub-module, go_sync_edge: 2-flop synchroniser plus rising-edge pulse, using the same async active-low reset.

Test Plan:
- Load-use: ex_memtoreg=1, ex_regwrite=1, ex_wreg=8, id_r1=8, id_r1_used=1 → for exactly 1 cycle: pc_en=0, ifid_en=0, idex_clr=1. stall_cnt +1.
- Branch beats stall: load-use condition plus ex_branch_taken=1 → pc_en=1, ifid_clr=1, idex_clr=1. flush_cnt +1, stall_cnt unchanged.
- Forward priority: ex_r1=5, ex_r1_used=1, mem_wreg=5, wb_wreg=5, both regwrite=1 → fwd_a=01. Same with mem_regwrite=0 → fwd_a=10. With ex_r1=0 → fwd_a=00.
- Halt/resume:
  - wb_syscall_halt=1 → next cycle halted=1 and all *_en=0.
  - Hold wb_syscall_halt=1 and raise go → 3 cycles later state is DRAIN with memwb_clr=1, then state is RUN.
  - There is no re-halt while wb_syscall_halt stays high during DRAIN.
- Async reset: drop rst_n mid-HALT between clock edges → immediately halted=0, all *_clr=1, all *_en=0. After release the state is RUN and counters are 0.
